// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order instruction queue: power-of-two ring buffer with push, pop and flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  fetch_entry_t             data_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push_i, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: head is only consumed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front-end: PC, credit-limited imem requests, response queue, decode handshake.
// Define FETCH_PERF_EN to add the perf_fetched / perf_dropped counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned     QDEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    pc_plus4,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_dropped
`endif
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  // Headroom beyond QDEPTH: repeated redirects can stack discards on top of live requests.
  localparam int unsigned IW = CW + 3;
  localparam logic [XLEN-1:0] PC0 = {RESET_PC[XLEN-1:2], 2'b00};

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [IW-1:0]   inflight_q, inflight_d;
  logic [IW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [IW-1:0]   live;
  logic [CW-1:0]   count;
  fetch_entry_t    head, push_entry;
  logic            accept, dropping, discard, push, pop;
  logic [XLEN-1:0] redirect_pc_aligned;

  assign redirect_pc_aligned = {redirect_pc[XLEN-1:2], 2'b00};

  assign live = IW'(count) + inflight_q - drop_cnt_q;
  // Gated by rst_n so the port reads idle while reset is held.
  assign imem_req_valid = rst_n && !redirect && (live < IW'(QDEPTH)) && (inflight_q != '1);
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign dropping = (state_q == DRAIN);
  assign discard  = imem_rsp_valid && (dropping || redirect);
  assign push     = imem_rsp_valid && !discard;
  assign pop      = instr_valid && instr_ready && !redirect;

  // Surviving responses belong to requests issued since the last redirect,
  // which are sequential, so a single running PC labels them.
  assign push_entry = '{instr: imem_rsp_data, pc: rsp_pc_q};

  always_comb begin
    inflight_d = inflight_q + IW'(accept) - IW'(imem_rsp_valid);
    drop_cnt_d = drop_cnt_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    if (redirect) begin
      drop_cnt_d = inflight_d;
      fetch_pc_d = redirect_pc_aligned;
      rsp_pc_d   = redirect_pc_aligned;
    end else begin
      if (discard) drop_cnt_d = drop_cnt_q - IW'(1);
      if (accept)  fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)    rsp_pc_d   = rsp_pc_q + 32'd4;
    end
    state_d = (drop_cnt_d != '0) ? DRAIN : RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      fetch_pc_q <= PC0;
      rsp_pc_q   <= PC0;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .data_i  (push_entry),
    .head_o  (head),
    .count_o (count)
  );

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? head.instr : '0;
  assign pc_plus4    = instr_valid ? (head.pc + 32'd4) : '0;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_dropped_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      if (pop)     perf_fetched_q <= perf_fetched_q + 32'd1;
      if (discard) perf_dropped_q <= perf_dropped_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural in-order memory of selectable latency.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .QDEPTH   (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .pc_plus4       (pc_plus4),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_dropped   (perf_dropped)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;
  int unsigned lat   = 1;
  int unsigned waited;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;
  pend_t pend[$];

  typedef struct {
    logic        rdy;
    logic        e_iv;
    logic [31:0] e_pc4;
    logic        e_rv;
    logic [31:0] e_addr;
  } vec_t;
  vec_t tbl[19];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t mk(input logic r, input logic iv, input logic [31:0] p4,
                              input logic rv, input logic [31:0] a);
    vec_t v;
    v.rdy = r; v.e_iv = iv; v.e_pc4 = p4; v.e_rv = rv; v.e_addr = a;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_rsp();
    if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  // Called at the negative edge: captures this cycle's handshakes, crosses the edge.
  task automatic edge_step();
    logic        acc, rv;
    logic [31:0] a;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    rv  = imem_rsp_valid;
    @(posedge clk);
    #1;
    cyc++;
    if (rv && pend.size() > 0) void'(pend.pop_front());
    if (acc) pend.push_back('{addr: a, due: cyc + lat});
    drive_rsp();
  endtask

  task automatic apply_reset(input int unsigned l);
    rst_n          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    pend.delete();
    lat = l;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic wait_valid(input string name, input int unsigned budget, output int unsigned w);
    w = 0;
    @(negedge clk);
    while (!instr_valid && w < budget) begin
      edge_step();
      w++;
      @(negedge clk);
    end
    n_vec++;
    if (!instr_valid) begin
      n_bad++;
      $display("FAIL %s: instr_valid got 0, expected 1 within %0d cycles", name, budget);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check32({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
    check32({tag, "_req_addr"},  imem_req_addr, 32'h0);
    check32({tag, "_iv"},        {31'b0, instr_valid}, 32'd0);
    check32({tag, "_instr"},     instr, 32'h0);
    check32({tag, "_pc4"},       pc_plus4, 32'h0);
`ifdef FETCH_PERF_EN
    check32({tag, "_perf_f"},    perf_fetched, 32'd0);
    check32({tag, "_perf_d"},    perf_dropped, 32'd0);
`endif
  endtask

  initial begin
    // Streaming with 1-cycle memory, then a 10-cycle decode stall (cycles 4..13).
    tbl[0] = mk(1'b1, 1'b0, 32'h00, 1'b1, 32'h00);
    tbl[1] = mk(1'b1, 1'b0, 32'h00, 1'b1, 32'h04);
    tbl[2] = mk(1'b1, 1'b1, 32'h04, 1'b1, 32'h08);
    tbl[3] = mk(1'b1, 1'b1, 32'h08, 1'b1, 32'h0C);
    tbl[4] = mk(1'b0, 1'b1, 32'h0C, 1'b1, 32'h10);
    tbl[5] = mk(1'b0, 1'b1, 32'h0C, 1'b1, 32'h14);
    tbl[6] = mk(1'b0, 1'b1, 32'h0C, 1'b0, 32'h18);
    for (int i = 7; i <= 13; i++) tbl[i] = mk(1'b0, 1'b1, 32'h0C, 1'b0, 32'h18);
    tbl[14] = mk(1'b1, 1'b1, 32'h0C, 1'b0, 32'h18);
    tbl[15] = mk(1'b1, 1'b1, 32'h10, 1'b1, 32'h18);
    tbl[16] = mk(1'b1, 1'b1, 32'h14, 1'b1, 32'h1C);
    tbl[17] = mk(1'b1, 1'b1, 32'h18, 1'b1, 32'h20);
    tbl[18] = mk(1'b1, 1'b1, 32'h1C, 1'b1, 32'h24);

    apply_reset(1);
    check_reset_outputs("rst");
    release_reset();

    for (int i = 0; i < 19; i++) begin
      instr_ready = tbl[i].rdy;
      @(negedge clk);
      check32($sformatf("v%0d_iv", i),    {31'b0, instr_valid}, {31'b0, tbl[i].e_iv});
      check32($sformatf("v%0d_pc4", i),   pc_plus4, tbl[i].e_pc4);
      check32($sformatf("v%0d_instr", i), instr,
              tbl[i].e_iv ? mem_word(tbl[i].e_pc4 - 32'd4) : 32'h0);
      check32($sformatf("v%0d_rv", i),    {31'b0, imem_req_valid}, {31'b0, tbl[i].e_rv});
      check32($sformatf("v%0d_addr", i),  imem_req_addr, tbl[i].e_addr);
      edge_step();
    end

    // Redirect coinciding with a response and a pop; low address bits ignored.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0043;
    @(negedge clk);
    check32("b_redir_rv", {31'b0, imem_req_valid}, 32'd0);
    check32("b_redir_iv", {31'b0, instr_valid}, 32'd1);
`ifdef FETCH_PERF_EN
    check32("b_perf_f0", perf_fetched, 32'd7);
    check32("b_perf_d0", perf_dropped, 32'd0);
`endif
    edge_step();
    redirect = 1'b0;
    @(negedge clk);
    check32("b_flushed_iv", {31'b0, instr_valid}, 32'd0);
    check32("b_next_rv",    {31'b0, imem_req_valid}, 32'd1);
    check32("b_next_addr",  imem_req_addr, 32'h0000_0040);
`ifdef FETCH_PERF_EN
    check32("b_perf_f1", perf_fetched, 32'd7);
    check32("b_perf_d1", perf_dropped, 32'd1);
`endif
    edge_step();
    @(negedge clk);
    check32("b_lat_iv", {31'b0, instr_valid}, 32'd0);
    edge_step();
    @(negedge clk);
    check32("b_first_iv",    {31'b0, instr_valid}, 32'd1);
    check32("b_first_pc4",   pc_plus4, 32'h0000_0044);
    check32("b_first_instr", instr, mem_word(32'h0000_0040));
    edge_step();

    // PC wrap at the top of the address space.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    @(negedge clk);
    check32("w_redir_rv", {31'b0, imem_req_valid}, 32'd0);
    edge_step();
    redirect = 1'b0;
    @(negedge clk);
    check32("w_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    check32("w_rv_top",   {31'b0, imem_req_valid}, 32'd1);
    edge_step();
    @(negedge clk);
    check32("w_addr_wrap", imem_req_addr, 32'h0000_0000);
    edge_step();
    @(negedge clk);
    check32("w_iv",    {31'b0, instr_valid}, 32'd1);
    check32("w_pc4",   pc_plus4, 32'h0000_0000);
    check32("w_instr", instr, mem_word(32'hFFFF_FFFC));

    // Asynchronous reset in the middle of a cycle, queue non-empty.
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");

    // 3-cycle memory, two requests in flight when redirecting to 0x100.
    apply_reset(3);
    release_reset();
    @(negedge clk);
    check32("a_c0_rv",   {31'b0, imem_req_valid}, 32'd1);
    check32("a_c0_addr", imem_req_addr, 32'h0);
    edge_step();
    @(negedge clk);
    edge_step();
    imem_req_ready = 1'b0;
    redirect       = 1'b1;
    redirect_pc    = 32'h0000_0100;
    @(negedge clk);
    check32("a_redir_rv", {31'b0, imem_req_valid}, 32'd0);
    edge_step();
    redirect       = 1'b0;
    imem_req_ready = 1'b1;
    wait_valid("a_wait", 20, waited);
    check32("a_latency", waited, 32'd4);
    check32("a_pc4",     pc_plus4, 32'h0000_0104);
    check32("a_instr",   instr, mem_word(32'h0000_0100));
`ifdef FETCH_PERF_EN
    check32("a_perf_d", perf_dropped, 32'd2);
`endif

    // Second redirect while still draining the first.
    apply_reset(3);
    release_reset();
    @(negedge clk);
    edge_step();
    @(negedge clk);
    edge_step();
    imem_req_ready = 1'b0;
    redirect       = 1'b1;
    redirect_pc    = 32'h0000_0100;
    @(negedge clk);
    edge_step();
    redirect       = 1'b0;
    imem_req_ready = 1'b1;
    @(negedge clk);
    check32("c_c3_addr", imem_req_addr, 32'h0000_0100);
    edge_step();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    @(negedge clk);
    check32("c_redir_rv", {31'b0, imem_req_valid}, 32'd0);
    edge_step();
    redirect = 1'b0;
    wait_valid("c_wait", 20, waited);
    check32("c_latency", waited, 32'd4);
    check32("c_pc4",     pc_plus4, 32'h0000_0204);
    check32("c_instr",   instr, mem_word(32'h0000_0200));
`ifdef FETCH_PERF_EN
    check32("c_perf_d", perf_dropped, 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule
